// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared VGA constants (1024x768 @ 60 Hz timing), the sprite
//               position FSM state encoding and a coordinate clamp helper.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    // 1024x768 @ 60 Hz, 65 MHz pixel clock
    localparam int H_TOTAL      = 1344;
    localparam int H_ACTIVE     = 1024;
    localparam int H_SYNC_START = 1048;
    localparam int H_SYNC_END   = 1184;
    localparam int V_TOTAL      = 806;
    localparam int V_ACTIVE     = 768;
    localparam int V_SYNC_START = 771;
    localparam int V_SYNC_END   = 777;

    // Sprite position request handshake states
    typedef enum logic [0:0] {
        POS_IDLE    = 1'b0,
        POS_PENDING = 1'b1
    } pos_state_t;

    // Pull a requested edge back so that the whole sprite stays on screen.
    // The sum is done in 12 bits so that a request near 2047 cannot wrap.
    function automatic logic [10:0] clamp_coord(
        input logic [10:0] req,
        input logic [11:0] size,
        input logic [11:0] limit
    );
        logic [11:0] w_end;
        w_end = {1'b0, req} + size;
        if (w_end > limit) begin
            return 11'(limit - size);
        end
        return req;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_if
// Description : VGA pixel-stream bundle passed between drawing stages.
//               Modport "in" is the consumer view, "out" the producer view.
// Fields      : hcount[10:0], vcount[10:0], hsync, vsync, hblnk, vblnk,
//               rgb[11:0]
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface
`default_nettype wire

// File: rtl/draw_rect_pos_ctl.sv
`default_nettype none
// ============================================================================
// Module      : draw_rect_pos_ctl
// Description : Sprite position request handshake. A request is clamped and
//               parked in a pending register, then promoted to the active
//               position at the next frame boundary so the sprite never
//               moves mid-frame.
// Ports       : clk, rst (async, active low)
//               i_pos_x/i_pos_y/i_pos_valid : position request
//               i_boundary                  : frame boundary strobe
//               o_pos_ready                 : request can be accepted
//               o_x_act/o_y_act             : active sprite position
// Revision    : 1.0 - initial release
// ============================================================================
module draw_rect_pos_ctl
    import vga_pkg::*;
#(
    parameter int RECT_W = 48,
    parameter int RECT_H = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] i_pos_x,
    input  logic [10:0] i_pos_y,
    input  logic        i_pos_valid,
    input  logic        i_boundary,
    output logic        o_pos_ready,
    output logic [10:0] o_x_act,
    output logic [10:0] o_y_act
);

    pos_state_t  r_state;
    pos_state_t  w_state_nxt;
    logic        w_capture;
    logic        w_apply;
    logic [10:0] r_x_pend;
    logic [10:0] r_y_pend;
    logic [10:0] r_x_act;
    logic [10:0] r_y_act;
    logic [10:0] w_x_clamped;
    logic [10:0] w_y_clamped;

    assign w_x_clamped = clamp_coord(i_pos_x, 12'(RECT_W), 12'(H_ACTIVE));
    assign w_y_clamped = clamp_coord(i_pos_y, 12'(RECT_H), 12'(V_ACTIVE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= POS_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A request taken in IDLE during a boundary cycle is only parked: the
    // apply path is reachable from PENDING alone, so it waits a full frame.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_apply     = 1'b0;
        case (r_state)
            POS_IDLE: begin
                if (i_pos_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = POS_PENDING;
                end
            end
            POS_PENDING: begin
                if (i_boundary) begin
                    w_apply     = 1'b1;
                    w_state_nxt = POS_IDLE;
                end
            end
            default: begin
                w_state_nxt = POS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x_pend <= 11'd0;
            r_y_pend <= 11'd0;
            r_x_act  <= 11'd0;
            r_y_act  <= 11'd0;
        end else begin
            if (w_capture) begin
                r_x_pend <= w_x_clamped;
                r_y_pend <= w_y_clamped;
            end
            if (w_apply) begin
                r_x_act <= r_x_pend;
                r_y_act <= r_y_pend;
            end
        end
    end

    assign o_pos_ready = (r_state == POS_IDLE);
    assign o_x_act     = r_x_act;
    assign o_y_act     = r_y_act;

endmodule
`default_nettype wire

// File: rtl/draw_rect_stage.sv
`default_nettype none
// ============================================================================
// Module      : draw_rect_stage
// Description : Overlays a solid RECT_W x RECT_H sprite on a VGA pixel
//               stream through a 2-stage pipeline. The sprite position is
//               requested through a ready/valid handshake and takes effect
//               at the next frame boundary (rising edge of vblnk).
// Ports       : clk, rst (async, active low)
//               vga_in     : upstream pixel stream
//               vga_out    : stream delayed 2 cycles with sprite overlaid
//               pos_x/pos_y/pos_valid/pos_ready : position request
//               frame_tick : 1-cycle pulse after each frame boundary
// Revision    : 1.0 - initial release
// ============================================================================
module draw_rect_stage
    import vga_pkg::*;
#(
    parameter int          RECT_W   = 48,
    parameter int          RECT_H   = 64,
    parameter logic [11:0] RECT_RGB = 12'hF_8_0
) (
    input  logic        clk,
    input  logic        rst,
    vga_if.in           vga_in,
    vga_if.out          vga_out,
    input  logic [10:0] pos_x,
    input  logic [10:0] pos_y,
    input  logic        pos_valid,
    output logic        pos_ready,
    output logic        frame_tick
);

    logic        r_vblnk_d;
    logic        r_hist_valid;
    logic        w_boundary;
    logic        r_frame_tick;
    logic [10:0] w_x_act;
    logic [10:0] w_y_act;
    logic        w_hit;

    logic [10:0] r_s1_hcount;
    logic [10:0] r_s1_vcount;
    logic        r_s1_hsync;
    logic        r_s1_vsync;
    logic        r_s1_hblnk;
    logic        r_s1_vblnk;
    logic [11:0] r_s1_rgb;
    logic        r_s1_hit;

    logic [10:0] r_s2_hcount;
    logic [10:0] r_s2_vcount;
    logic        r_s2_hsync;
    logic        r_s2_vsync;
    logic        r_s2_hblnk;
    logic        r_s2_vblnk;
    logic [11:0] r_s2_rgb;

    // The history flag stops the first cycle after reset from looking like
    // a 0->1 vblnk edge just because the history register was cleared.
    assign w_boundary = vga_in.vblnk & ~r_vblnk_d & r_hist_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vblnk_d    <= 1'b0;
            r_hist_valid <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_vblnk_d    <= vga_in.vblnk;
            r_hist_valid <= 1'b1;
            r_frame_tick <= w_boundary;
        end
    end

    draw_rect_pos_ctl #(
        .RECT_W (RECT_W),
        .RECT_H (RECT_H)
    ) u_pos_ctl (
        .clk         (clk),
        .rst         (rst),
        .i_pos_x     (pos_x),
        .i_pos_y     (pos_y),
        .i_pos_valid (pos_valid),
        .i_boundary  (w_boundary),
        .o_pos_ready (pos_ready),
        .o_x_act     (w_x_act),
        .o_y_act     (w_y_act)
    );

    // Compare in 12 bits so that x_act + RECT_W can reach 2048 without wrap
    logic [11:0] w_hc;
    logic [11:0] w_vc;
    logic [11:0] w_xa;
    logic [11:0] w_ya;

    assign w_hc  = {1'b0, vga_in.hcount};
    assign w_vc  = {1'b0, vga_in.vcount};
    assign w_xa  = {1'b0, w_x_act};
    assign w_ya  = {1'b0, w_y_act};
    assign w_hit = (w_hc >= w_xa) && (w_hc < (w_xa + 12'(RECT_W))) &&
                   (w_vc >= w_ya) && (w_vc < (w_ya + 12'(RECT_H))) &&
                   !vga_in.hblnk && !vga_in.vblnk;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_hcount <= 11'd0;
            r_s1_vcount <= 11'd0;
            r_s1_hsync  <= 1'b0;
            r_s1_vsync  <= 1'b0;
            r_s1_hblnk  <= 1'b0;
            r_s1_vblnk  <= 1'b0;
            r_s1_rgb    <= 12'd0;
            r_s1_hit    <= 1'b0;
            r_s2_hcount <= 11'd0;
            r_s2_vcount <= 11'd0;
            r_s2_hsync  <= 1'b0;
            r_s2_vsync  <= 1'b0;
            r_s2_hblnk  <= 1'b0;
            r_s2_vblnk  <= 1'b0;
            r_s2_rgb    <= 12'd0;
        end else begin
            r_s1_hcount <= vga_in.hcount;
            r_s1_vcount <= vga_in.vcount;
            r_s1_hsync  <= vga_in.hsync;
            r_s1_vsync  <= vga_in.vsync;
            r_s1_hblnk  <= vga_in.hblnk;
            r_s1_vblnk  <= vga_in.vblnk;
            r_s1_rgb    <= vga_in.rgb;
            r_s1_hit    <= w_hit;
            r_s2_hcount <= r_s1_hcount;
            r_s2_vcount <= r_s1_vcount;
            r_s2_hsync  <= r_s1_hsync;
            r_s2_vsync  <= r_s1_vsync;
            r_s2_hblnk  <= r_s1_hblnk;
            r_s2_vblnk  <= r_s1_vblnk;
            r_s2_rgb    <= r_s1_hit ? RECT_RGB : r_s1_rgb;
        end
    end

    assign vga_out.hcount = r_s2_hcount;
    assign vga_out.vcount = r_s2_vcount;
    assign vga_out.hsync  = r_s2_hsync;
    assign vga_out.vsync  = r_s2_vsync;
    assign vga_out.hblnk  = r_s2_hblnk;
    assign vga_out.vblnk  = r_s2_vblnk;
    assign vga_out.rgb    = r_s2_rgb;
    assign frame_tick     = r_frame_tick;

endmodule
`default_nettype wire

// File: doc/draw_rect_stage.md
DRAW_RECT_STAGE -- requirements
Module: draw_rect_stage

Interface
REQ-001 Parameter RECT_W, default 48, sprite width in pixels (1..H_ACTIVE).
REQ-002 Parameter RECT_H, default 64, sprite height in pixels (1..V_ACTIVE).
REQ-003 Parameter RECT_RGB, default 12'hF_8_0, sprite fill colour.
REQ-004 clk  input  1  pixel clock; the block's only clock.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 vga_in  vga_if.in  bundle  hcount[10:0], vcount[10:0], hsync, vsync, hblnk, vblnk, rgb[11:0] from the upstream stage.
REQ-007 vga_out  vga_if.out  bundle  the same fields, delayed, with the sprite overlaid.
REQ-008 pos_x  input  11  requested sprite left edge.
REQ-009 pos_y  input  11  requested sprite top edge.
REQ-010 pos_valid  input  1  position request.
REQ-011 pos_ready  output  1  block can accept a position.
REQ-012 frame_tick  output  1  one-cycle pulse on each frame boundary.

Function
REQ-013 Frame boundary SHALL be the first cycle where vga_in.vblnk=1 and vga_in.vblnk was 0 in the previous cycle.
REQ-014 Position FSM states SHALL be IDLE (pos_ready=1) and PENDING (pos_ready=0).
REQ-015 In IDLE, pos_valid=1 SHALL capture pos_x/pos_y into a pending register and move the FSM to PENDING.
REQ-016 In PENDING, a frame boundary SHALL copy pending to the active position and return the FSM to IDLE.
REQ-017 A request accepted in the same cycle as a frame boundary SHALL NOT be applied at that boundary; it is applied at the next boundary.
REQ-018 The active position SHALL change only at a frame boundary, never mid-frame.
REQ-019 On capture, x SHALL be clamped to H_ACTIVE-RECT_W and y to V_ACTIVE-RECT_H when exceeded, using 12-bit sums to avoid wrap.
REQ-020 Pixel hit SHALL be x_act<=hcount<x_act+RECT_W and y_act<=vcount<y_act+RECT_H and hblnk=0 and vblnk=0.
REQ-021 Pipeline SHALL be 2 stages.
  - Stage 1: register the vga_in fields and the hit flag.
  - Stage 2: register the output, rgb = hit ? RECT_RGB : stage-1 rgb.
REQ-022 All vga_out fields SHALL have exactly 2 cycles latency and stay mutually aligned.
REQ-023 frame_tick SHALL be asserted in the cycle after the boundary is detected, for exactly 1 cycle.
REQ-024 Blanked pixels SHALL pass the input rgb unchanged.

Reset
REQ-025 rst=0 SHALL asynchronously clear every vga_out field to 0.
REQ-026 rst=0 SHALL clear frame_tick, both pipeline stages and the vblnk history register to 0.
REQ-027 rst=0 SHALL set the active and pending positions to (0,0) and the FSM to IDLE (pos_ready=1).
REQ-028 Reset mid-frame SHALL discard any pending request.
REQ-029 After reset release, the first boundary SHALL be detected only from a real 0->1 vblnk transition.

Structure
REQ-030 H_ACTIVE, V_ACTIVE and the FSM state enum SHALL live in vga_pkg, next to the existing timing constants.
REQ-031 The position capture/clamp FSM SHALL be the sub-module draw_rect_pos_ctl; the pixel pipeline stays in the top.

Verification
REQ-032 Position (100,200) accepted mid-frame -> vga_out unchanged that frame; from the next frame, rgb=RECT_RGB exactly at hcount 100..147, vcount 200..263.
REQ-033 pos_valid held high for 3 cycles -> only the first is accepted; pos_ready=0 until the boundary, then 1 the cycle after.
REQ-034 pos=(1020,760) at 1024x768 -> sprite drawn at (976,704).
REQ-035 Request arriving in the boundary cycle -> applied only one frame later; frame_tick pulses once per frame.
REQ-036 Random vga_in stream -> every vga_out field equals the input 2 cycles earlier, except rgb inside the sprite.
REQ-037 rst=0 during an active line -> all outputs 0 immediately, position (0,0), pos_ready=1; normal operation resumes 2 cycles after release.
